// File: rtl/adder_sequencer.sv
// Fetch/decode/execute sequencer for the adding machine: drives memory reads and the ALU, owns PC/IR/AC.
// Optional macro SEQ_CARRY_FLAG_EN adds a carry_flag output updated by ADD and cleared by LDA.
module adder_sequencer #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_pass_add,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] ac_out,
  output logic              halted
`ifdef SEQ_CARRY_FLAG_EN
  ,
  output logic              carry_flag
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    OPRD,
    EXEC,
    HALT
  } state_t;

  localparam logic [1:0] OP_LDA = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_NOP = 2'b10;
  localparam logic [1:0] OP_HLT = 2'b11;
  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] ac;
  logic [ADDR_W-1:0] addr_hold;
  logic [1:0]        ir_op;
  logic [1:0]        fetched_op;

  assign ir_op      = ir[DATA_W-1 -: 2];
  assign fetched_op = mem_rdata[DATA_W-1 -: 2];
  assign ac_out     = ac;
  assign halted     = (state == HALT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // mem_addr must keep its last driven value outside the read states, so it is echoed into addr_hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= PC_INIT;
      ir        <= '0;
      ac        <= '0;
      addr_hold <= '0;
    end else begin
      addr_hold <= mem_addr;
      if (state == DECODE) begin
        ir <= mem_rdata;
        pc <= pc + ADDR_W'(1);
      end
      if (state == EXEC) begin
        ac <= alu_result;
      end
    end
  end

`ifdef SEQ_CARRY_FLAG_EN
  // A wrapped sum is always smaller than the accumulator it started from.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_flag <= 1'b0;
    end else if (state == EXEC) begin
      carry_flag <= (ir_op == OP_ADD) ? (alu_result < ac) : 1'b0;
    end
  end
`endif

  always_comb begin
    state_next   = state;
    mem_addr     = addr_hold;
    mem_rd       = 1'b0;
    alu_a        = ac;
    alu_b        = '0;
    alu_pass_add = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_next = FETCH;
      end
      FETCH: begin
        mem_addr   = pc;
        mem_rd     = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        case (fetched_op)
          OP_LDA:  state_next = OPRD;
          OP_ADD:  state_next = EXEC;
          OP_NOP:  state_next = FETCH;
          OP_HLT:  state_next = HALT;
          default: state_next = FETCH;
        endcase
      end
      OPRD: begin
        mem_addr   = ir[ADDR_W-1:0];
        mem_rd     = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        if (ir_op == OP_ADD) begin
          alu_b        = DATA_W'(ir[ADDR_W-1:0]);
          alu_pass_add = 1'b1;
        end else begin
          alu_a = mem_rdata;
        end
        state_next = FETCH;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_adder_sequencer.sv
// Bench for adder_sequencer: directed scenarios plus random programs checked against an instruction-level model.
// A second instance with RESET_PC=1 exercises the program counter wrap.
module tb_adder_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       run_w = 1'b0;
  logic [7:0] mem [64];

  logic [5:0] mem_addr, mem_addr_w;
  logic       mem_rd, mem_rd_w;
  logic [7:0] mem_rdata, mem_rdata_w;
  logic [7:0] alu_a, alu_b, alu_result, alu_a_w, alu_b_w, alu_result_w;
  logic       alu_pass_add, alu_pass_add_w;
  logic [7:0] ac_out, ac_out_w;
  logic       halted, halted_w;
  logic       carry_flag, carry_flag_w;

  int vectors = 0;
  int miscompares = 0;

  logic [5:0] log_addr[$];
  logic [7:0] log_ac[$];
  logic       log_cy[$];
  logic [5:0] wlog_addr[$];
  int         pass_count;

  logic [5:0] exp_addr[$];
  logic [7:0] exp_ac[$];
  logic       exp_cy[$];

  always #5 clk = ~clk;

  adder_sequencer #(.DATA_W(8), .ADDR_W(6), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_pass_add(alu_pass_add), .alu_result(alu_result),
    .ac_out(ac_out), .halted(halted)
`ifdef SEQ_CARRY_FLAG_EN
    , .carry_flag(carry_flag)
`endif
  );

  adder_sequencer #(.DATA_W(8), .ADDR_W(6), .RESET_PC(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .run(run_w),
    .mem_addr(mem_addr_w), .mem_rd(mem_rd_w), .mem_rdata(mem_rdata_w),
    .alu_a(alu_a_w), .alu_b(alu_b_w), .alu_pass_add(alu_pass_add_w), .alu_result(alu_result_w),
    .ac_out(ac_out_w), .halted(halted_w)
`ifdef SEQ_CARRY_FLAG_EN
    , .carry_flag(carry_flag_w)
`endif
  );

`ifndef SEQ_CARRY_FLAG_EN
  assign carry_flag   = 1'b0;
  assign carry_flag_w = 1'b0;
`endif

  // Environment: combinational ALU and one-cycle-latency memory per instance.
  assign alu_result   = alu_pass_add ? alu_a + alu_b : alu_a;
  assign alu_result_w = alu_pass_add_w ? alu_a_w + alu_b_w : alu_a_w;

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_rd_w) mem_rdata_w <= mem[mem_addr_w];
  end

  always @(negedge clk) begin
    if (mem_rd) begin
      log_addr.push_back(mem_addr);
      log_ac.push_back(ac_out);
      log_cy.push_back(carry_flag);
    end
    if (mem_rd_w) wlog_addr.push_back(mem_addr_w);
    if (alu_pass_add) pass_count++;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    run_w = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_ac.delete();
    log_cy.delete();
    wlog_addr.delete();
    pass_count = 0;
  endtask

  task automatic fill_mem(input logic [7:0] value);
    for (int i = 0; i < 64; i++) mem[i] = value;
  endtask

  // Pulses run and counts clock edges from the FETCH entry edge until halted rises.
  task automatic run_program(output int cycles, output bit timed_out);
    clear_logs();
    cycles    = 0;
    timed_out = 1'b0;
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    while (1) begin
      @(posedge clk);
      cycles++;
      #1;
      if (halted) break;
      if (cycles > 2000) begin
        timed_out = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  // Instruction-level reference: every memory read carries the AC/carry visible while it happens.
  task automatic model_run(input int start_pc, output int cycles, output int adds,
                           output logic [7:0] final_ac);
    int pc, acc, cy, ins, opd;
    exp_addr.delete();
    exp_ac.delete();
    exp_cy.delete();
    pc = start_pc; acc = 0; cy = 0; cycles = 0; adds = 0;
    for (int n = 0; n < 1000; n++) begin
      ins = mem[pc];
      opd = ins % 64;
      exp_addr.push_back(6'(pc));
      exp_ac.push_back(8'(acc));
      exp_cy.push_back(cy != 0);
      pc = (pc + 1) % 64;
      if (ins / 64 == 0) begin
        exp_addr.push_back(6'(opd));
        exp_ac.push_back(8'(acc));
        exp_cy.push_back(cy != 0);
        acc = mem[opd];
        cy = 0;
        cycles += 4;
      end else if (ins / 64 == 1) begin
        acc = acc + opd;
        cy = (acc > 255) ? 1 : 0;
        acc = acc % 256;
        adds++;
        cycles += 3;
      end else if (ins / 64 == 2) begin
        cycles += 2;
      end else begin
        cycles += 2;
        break;
      end
    end
    final_ac = 8'(acc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    run_w = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (ac_out !== 8'h00 || halted !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== 6'd0 ||
          alu_pass_add !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_idle cycle %0d: ac=%h halted=%b mem_rd=%b addr=%h pass=%b, want 00 0 0 00 0",
                 i, ac_out, halted, mem_rd, mem_addr, alu_pass_add);
      end
    end
  endtask

  task automatic test_lda_hlt();
    fill_mem(8'h00);
    mem[0] = 8'h05;
    mem[1] = 8'hC0;
    mem[5] = 8'hA7;
    do_reset();
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      if (e == 3) begin
        vectors++;
        if (ac_out !== 8'h00) begin
          miscompares++;
          $display("[TB] FAIL lda_early: ac=%h, want 00", ac_out);
        end
      end
      if (e == 4) begin
        vectors++;
        if (ac_out !== 8'hA7) begin
          miscompares++;
          $display("[TB] FAIL lda_latency: ac=%h, want a7", ac_out);
        end
      end
      if (e == 5 || e == 6) begin
        vectors++;
        if (halted !== (e == 6)) begin
          miscompares++;
          $display("[TB] FAIL hlt_edge%0d: halted=%b, want %b", e, halted, e == 6);
        end
      end
    end
    run = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    vectors++;
    if (halted !== 1'b1 || mem_rd !== 1'b0 || ac_out !== 8'hA7) begin
      miscompares++;
      $display("[TB] FAIL halt_hold: halted=%b mem_rd=%b ac=%h, want 1 0 a7", halted, mem_rd, ac_out);
    end
  endtask

  task automatic test_add_chain();
    int cycles;
    bit to;
    fill_mem(8'h00);
    mem[0] = 8'h20; mem[1] = 8'h7F; mem[2] = 8'h41; mem[3] = 8'hC0;
    mem[6'h20] = 8'h10;
    do_reset();
    run_program(cycles, to);
    vectors++;
    if (to || cycles !== 12) begin
      miscompares++;
      $display("[TB] FAIL add_chain_cycles: cycles=%0d timeout=%0d, want 12 0", cycles, to);
    end
    vectors++;
    if (ac_out !== 8'h50) begin
      miscompares++;
      $display("[TB] FAIL add_chain_ac: ac=%h, want 50", ac_out);
    end
    vectors++;
    if (pass_count !== 2) begin
      miscompares++;
      $display("[TB] FAIL add_chain_pass: pass_add cycles=%0d, want 2", pass_count);
    end
  endtask

  task automatic test_wrap_carry();
    int cycles;
    bit to;
    fill_mem(8'h00);
    mem[0] = 8'h30; mem[1] = 8'h7F; mem[2] = 8'h31; mem[3] = 8'hC0;
    mem[6'h30] = 8'hF0; mem[6'h31] = 8'h12;
    do_reset();
    run_program(cycles, to);
    vectors++;
    if (to || log_addr.size() != 6) begin
      miscompares++;
      $display("[TB] FAIL wrap_reads: reads=%0d timeout=%0d, want 6 0", log_addr.size(), to);
    end else begin
      vectors++;
      if (log_addr[3] !== 6'd2 || log_ac[3] !== 8'h2F) begin
        miscompares++;
        $display("[TB] FAIL wrap_sum: addr=%h ac=%h, want 02 2f", log_addr[3], log_ac[3]);
      end
`ifdef SEQ_CARRY_FLAG_EN
      vectors++;
      if (log_cy[3] !== 1'b1 || log_cy[5] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL wrap_carry: after add=%b after lda=%b, want 1 0", log_cy[3], log_cy[5]);
      end
`endif
    end
    vectors++;
    if (ac_out !== 8'h12) begin
      miscompares++;
      $display("[TB] FAIL wrap_final: ac=%h, want 12", ac_out);
    end
  endtask

  task automatic test_pc_wrap();
    int cycles;
    bit to;
    fill_mem(8'h80);
    mem[0] = 8'hC0;
    do_reset();
    clear_logs();
    cycles = 0;
    to = 1'b0;
    @(negedge clk);
    run_w = 1'b1;
    @(posedge clk);
    #1 run_w = 1'b0;
    while (1) begin
      @(posedge clk);
      cycles++;
      #1;
      if (halted_w) break;
      if (cycles > 2000) begin
        to = 1'b1;
        break;
      end
    end
    @(negedge clk);
    vectors++;
    if (to || cycles !== 128 || wlog_addr.size() != 64) begin
      miscompares++;
      $display("[TB] FAIL pc_wrap_run: cycles=%0d fetches=%0d timeout=%0d, want 128 64 0",
               cycles, wlog_addr.size(), to);
    end else begin
      for (int i = 0; i < 64; i++) begin
        vectors++;
        if (wlog_addr[i] !== 6'((i + 1) % 64)) begin
          miscompares++;
          $display("[TB] FAIL pc_wrap_addr[%0d]: addr=%0d, want %0d", i, wlog_addr[i], (i + 1) % 64);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int cycles;
    bit to;
    fill_mem(8'h00);
    mem[0] = 8'h20; mem[1] = 8'hC0;
    mem[6'h20] = 8'h77;
    do_reset();
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (mem_rd !== 1'b1 || mem_addr !== 6'h20) begin
      miscompares++;
      $display("[TB] FAIL mid_oprd: mem_rd=%b addr=%h, want 1 20", mem_rd, mem_addr);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (ac_out !== 8'h00 || mem_rd !== 1'b0 || halted !== 1'b0 || mem_addr !== 6'd0) begin
      miscompares++;
      $display("[TB] FAIL mid_abort: ac=%h mem_rd=%b halted=%b addr=%h, want 00 0 0 00",
               ac_out, mem_rd, halted, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (mem_rd !== 1'b0 || ac_out !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL mid_idle: mem_rd=%b ac=%h, want 0 00", mem_rd, ac_out);
    end
    run_program(cycles, to);
    vectors++;
    if (to || log_addr.size() == 0 || log_addr[0] !== 6'd0 || ac_out !== 8'h77) begin
      miscompares++;
      $display("[TB] FAIL mid_restart: timeout=%0d first_addr=%h ac=%h, want 0 00 77",
               to, (log_addr.size() > 0) ? log_addr[0] : 6'h3F, ac_out);
    end
  endtask

  task automatic test_random_programs();
    int cycles, exp_cycles, exp_adds, len, op;
    bit to;
    logic [7:0] exp_final;
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      len = $urandom_range(3, 12);
      for (int i = 0; i < len; i++) begin
        op = $urandom_range(0, 2);
        mem[i] = {2'(op), 6'($urandom)};
      end
      mem[len] = 8'hC0;
      model_run(0, exp_cycles, exp_adds, exp_final);
      do_reset();
      run_program(cycles, to);
      vectors++;
      if (to || cycles != exp_cycles || pass_count != exp_adds) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_timing: cycles=%0d adds=%0d timeout=%0d, want %0d %0d 0",
                 it, cycles, pass_count, to, exp_cycles, exp_adds);
      end
      vectors++;
      if (ac_out !== exp_final) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_ac: ac=%h, want %h", it, ac_out, exp_final);
      end
      vectors++;
      if (log_addr.size() != exp_addr.size()) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_reads: count=%0d, want %0d", it, log_addr.size(), exp_addr.size());
      end else begin
        for (int i = 0; i < exp_addr.size(); i++) begin
          vectors++;
          if (log_addr[i] !== exp_addr[i] || log_ac[i] !== exp_ac[i]
`ifdef SEQ_CARRY_FLAG_EN
              || log_cy[i] !== exp_cy[i]
`endif
             ) begin
            miscompares++;
            $display("[TB] FAIL rand%0d_read%0d: addr=%h ac=%h cy=%b, want %h %h %b",
                     it, i, log_addr[i], log_ac[i], log_cy[i], exp_addr[i], exp_ac[i], exp_cy[i]);
          end
        end
      end
    end
  endtask

  initial begin
    pass_count = 0;
    test_reset();
    test_lda_hlt();
    test_add_chain();
    test_wrap_carry();
    test_pc_wrap();
    test_mid_reset();
    test_random_programs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
